// File: rtl/rvv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rvv_pkg                                                                    |
// | Shared vtype encodings, register-file geometry and mask helpers for the    |
// | vector sequencer slice.                                                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package rvv_pkg;

  localparam int VLEN    = 128;
  localparam int VLENB   = VLEN / 8;
  localparam int VREG_AW = 5;

  localparam logic [2:0] SEW_8  = 3'd0;
  localparam logic [2:0] SEW_16 = 3'd1;
  localparam logic [2:0] SEW_32 = 3'd2;
  localparam logic [2:0] SEW_64 = 3'd3;

  localparam logic [2:0] LMUL_1 = 3'd0;
  localparam logic [2:0] LMUL_2 = 3'd1;
  localparam logic [2:0] LMUL_4 = 3'd2;
  localparam logic [2:0] LMUL_8 = 3'd3;

  // Elements per register for a legal SEW encoding.
  function automatic logic [4:0] epr_of(input logic [1:0] sew_enc);
    return 5'd16 >> sew_enc;
  endfunction

  // Low-order byte mask with nbytes ones; 16 bytes yields all ones.
  function automatic logic [VLENB-1:0] bytes_to_mask(input logic [4:0] nbytes);
    logic [VLENB:0] one_v;
    logic [VLENB:0] m;
    one_v    = '0;
    one_v[0] = 1'b1;
    m        = (one_v << nbytes) - one_v;
    return m[VLENB-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rvv_wb_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rvv_wb_delay                                                               |
// | EX_LAT-deep valid/wa/wbe shift line feeding registered write-back outputs, |
// | with an empty flag covering the in-flight stages.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rvv_wb_delay
  import rvv_pkg::*;
#(
  parameter int EX_LAT = 1,
  parameter int WBE_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic [VREG_AW-1:0] i_wa,
  input  logic [WBE_W-1:0]   i_wbe,
  output logic               o_wen,
  output logic [VREG_AW-1:0] o_wa,
  output logic [WBE_W-1:0]   o_wbe,
  output logic               o_empty
);

  logic [EX_LAT-1:0]  r_vld;
  logic [VREG_AW-1:0] r_wa  [EX_LAT];
  logic [WBE_W-1:0]   r_wbe [EX_LAT];
  logic               r_wen;
  logic [VREG_AW-1:0] r_wa_out;
  logic [WBE_W-1:0]   r_wbe_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      for (int i = 0; i < EX_LAT; i++) begin
        r_wa[i]  <= '0;
        r_wbe[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_valid;
      r_wa[0]  <= i_wa;
      r_wbe[0] <= i_wbe;
      for (int i = 1; i < EX_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_wa[i]  <= r_wa[i-1];
        r_wbe[i] <= r_wbe[i-1];
      end
    end
  end

  // Address and mask read as zero whenever no write is presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wen     <= 1'b0;
      r_wa_out  <= '0;
      r_wbe_out <= '0;
    end else begin
      r_wen     <= r_vld[EX_LAT-1];
      r_wa_out  <= r_vld[EX_LAT-1] ? r_wa[EX_LAT-1]  : '0;
      r_wbe_out <= r_vld[EX_LAT-1] ? r_wbe[EX_LAT-1] : '0;
    end
  end

  assign o_wen   = r_wen;
  assign o_wa    = r_wa_out;
  assign o_wbe   = r_wbe_out;
  assign o_empty = ~|r_vld;

endmodule

`default_nettype wire

// File: rtl/rvv_vseq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rvv_vseq                                                                   |
// | Vector micro-op sequencer: expands one whole-group instruction into        |
// | per-register read/ALU micro-ops and delayed write-backs, then waits for    |
// | the write-backs to retire. RVV_VSEQ_TAIL_MASK_EN enables tail byte masks.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rvv_vseq #(
  parameter int EX_LAT = 1,
  parameter int VLEN   = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_vs1,
  input  logic [4:0]        in_vs2,
  input  logic [4:0]        in_vd,
  input  logic [2:0]        in_op,
  input  logic [8:0]        vl,
  input  logic [2:0]        sew_enc,
  input  logic [2:0]        lmul_enc,
  input  logic              stall,
  output logic [4:0]        raA,
  output logic [4:0]        raB,
  output logic              rd_valid,
  output logic [2:0]        valu_op,
  output logic [4:0]        wa,
  output logic              wen,
  output logic [VLEN/8-1:0] wbe,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import rvv_pkg::*;

  localparam int         c_WBE_W    = VLEN / 8;
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;

  logic [4:0]         r_vs1;
  logic [4:0]         r_vs2;
  logic [4:0]         r_vd;
  logic [2:0]         r_op;
  logic [3:0]         r_nregs;
  logic [3:0]         r_k;
  logic               r_ill;

  logic               r_rd_valid;
  logic [4:0]         r_raA;
  logic [4:0]         r_raB;
  logic [2:0]         r_valu_op;
  logic               r_done;
  logic               r_err;

  logic               w_accept;
  logic               w_issue;
  logic               w_last;
  logic               w_drained;
  logic               w_wb_empty;
  logic               w_ill;
  logic [4:0]         w_epr_in;
  logic [9:0]         w_groups;
  logic [3:0]         w_lmax;
  logic [3:0]         w_nregs;
  logic [4:0]         w_k5;
  logic [4:0]         w_wa_in;
  logic [c_WBE_W-1:0] w_wbe_in;

  // Register count at accept: ceil(vl/epr) clamped to the LMUL group size.
  always_comb begin
    w_ill    = (sew_enc > SEW_64) || (lmul_enc > LMUL_8);
    w_epr_in = epr_of(sew_enc[1:0]);
    w_groups = ({1'b0, vl} + {5'd0, w_epr_in} - 10'd1) >> (3'd4 - {1'b0, sew_enc[1:0]});
    w_lmax   = 4'd1 << lmul_enc[1:0];
    if (w_ill) begin
      w_nregs = 4'd0;
    end else if (w_groups < {6'd0, w_lmax}) begin
      w_nregs = w_groups[3:0];
    end else begin
      w_nregs = w_lmax;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_nregs == 4'd0) ? c_ST_DRAIN : c_ST_ISSUE;
        end
      end
      c_ST_ISSUE: begin
        if (w_last) begin
          w_state_nxt = c_ST_DRAIN;
        end
      end
      c_ST_DRAIN: begin
        if (w_wb_empty) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == c_ST_IDLE);
    busy      = (r_state != c_ST_IDLE);
    w_accept  = in_valid & in_ready;
    w_issue   = (r_state == c_ST_ISSUE) & ~stall;
    w_last    = w_issue & (r_k == (r_nregs - 4'd1));
    w_drained = (r_state == c_ST_DRAIN) & w_wb_empty;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vs1   <= '0;
      r_vs2   <= '0;
      r_vd    <= '0;
      r_op    <= '0;
      r_nregs <= '0;
      r_ill   <= 1'b0;
      r_k     <= '0;
    end else if (w_accept) begin
      r_vs1   <= in_vs1;
      r_vs2   <= in_vs2;
      r_vd    <= in_vd;
      r_op    <= in_op;
      r_nregs <= w_nregs;
      r_ill   <= w_ill;
      r_k     <= '0;
    end else if (w_issue) begin
      r_k     <= r_k + 4'd1;
    end
  end

  assign w_k5    = {1'b0, r_k};
  assign w_wa_in = r_vd + w_k5;

  // Read side holds its last address through stall bubbles; only rd_valid drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_valid <= 1'b0;
      r_raA      <= '0;
      r_raB      <= '0;
      r_valu_op  <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= w_issue;
      if (w_issue) begin
        r_raA     <= r_vs1 + w_k5;
        r_raB     <= r_vs2 + w_k5;
        r_valu_op <= r_op;
      end
      r_done <= w_drained;
      r_err  <= w_drained & r_ill;
    end
  end

`ifdef RVV_VSEQ_TAIL_MASK_EN
  logic [8:0] r_vl;
  logic [1:0] r_sew;
  logic [4:0] w_epr;
  logic [9:0] w_rem;
  logic [4:0] w_bytes;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vl  <= '0;
      r_sew <= '0;
    end else if (w_accept) begin
      r_vl  <= vl;
      r_sew <= sew_enc[1:0];
    end
  end

  // Elements left for register k; only a short last register gets a partial mask.
  always_comb begin
    w_epr = epr_of(r_sew);
    w_rem = {1'b0, r_vl} - ({6'd0, r_k} << (3'd4 - {1'b0, r_sew}));
    if (w_rem >= {5'd0, w_epr}) begin
      w_bytes = 5'd16;
    end else begin
      w_bytes = w_rem[4:0] << r_sew;
    end
    w_wbe_in = bytes_to_mask(w_bytes);
  end
`else
  assign w_wbe_in = '1;
`endif

  rvv_wb_delay #(
    .EX_LAT (EX_LAT),
    .WBE_W  (c_WBE_W)
  ) u_wb_delay (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_issue),
    .i_wa    (w_wa_in),
    .i_wbe   (w_wbe_in),
    .o_wen   (wen),
    .o_wa    (wa),
    .o_wbe   (wbe),
    .o_empty (w_wb_empty)
  );

  assign rd_valid = r_rd_valid;
  assign raA      = r_raA;
  assign raB      = r_raB;
  assign valu_op  = r_valu_op;
  assign done     = r_done;
  assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rvv_vseq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rvv_vseq                                                                |
// | Directed and randomized stimulus for rvv_vseq against a per-cycle schedule |
// | model computed from the instruction expansion rules.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_rvv_vseq;

  localparam int EX_LAT = 1;
  localparam int NCYC   = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_vs1 = '0;
  logic [4:0]  in_vs2 = '0;
  logic [4:0]  in_vd = '0;
  logic [2:0]  in_op = '0;
  logic [8:0]  vl = '0;
  logic [2:0]  sew_enc = '0;
  logic [2:0]  lmul_enc = '0;
  logic        stall = 1'b0;

  logic        in_ready;
  logic [4:0]  raA;
  logic [4:0]  raB;
  logic        rd_valid;
  logic [2:0]  valu_op;
  logic [4:0]  wa;
  logic        wen;
  logic [15:0] wbe;
  logic        busy;
  logic        done;
  logic        err;

  rvv_vseq #(
    .EX_LAT (EX_LAT),
    .VLEN   (128)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vs1   (in_vs1),
    .in_vs2   (in_vs2),
    .in_vd    (in_vd),
    .in_op    (in_op),
    .vl       (vl),
    .sew_enc  (sew_enc),
    .lmul_enc (lmul_enc),
    .stall    (stall),
    .raA      (raA),
    .raB      (raB),
    .rd_valid (rd_valid),
    .valu_op  (valu_op),
    .wa       (wa),
    .wen      (wen),
    .wbe      (wbe),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Expected per-cycle observations, indexed by cycle number.
  bit          e_rdv  [NCYC];
  logic [4:0]  e_raA  [NCYC];
  logic [4:0]  e_raB  [NCYC];
  logic [2:0]  e_op   [NCYC];
  bit          e_wen  [NCYC];
  logic [4:0]  e_wa   [NCYC];
  logic [15:0] e_wbe  [NCYC];
  bit          e_done [NCYC];
  bit          e_err  [NCYC];
  bit          e_busy [NCYC];
  bit          stall_pat [NCYC];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < NCYC; i++) begin
      e_rdv[i]  = 1'b0;
      e_raA[i]  = '0;
      e_raB[i]  = '0;
      e_op[i]   = '0;
      e_wen[i]  = 1'b0;
      e_wa[i]   = '0;
      e_wbe[i]  = '0;
      e_done[i] = 1'b0;
      e_err[i]  = 1'b0;
      e_busy[i] = 1'b0;
    end
  endtask

  // Instruction accepted at the end of cycle c: the group's registers are read
  // one per non-stalled ISSUE cycle starting at c+1 (visible one cycle later),
  // written EX_LAT cycles after their read, and done follows the last write.
  task automatic plan(input int c, input int a, input int b, input int d,
                      input int op, input int l, input int s, input int m);
    int nregs, epr, j, t, rem, nb, fin;
    bit ill;
    logic [15:0] mask;
    ill   = (s > 3) || (m > 3);
    nregs = 0;
    epr   = 1;
    t     = c;
    if (!ill) begin
      epr   = 16 >> s;
      nregs = (l + epr - 1) / epr;
      if (nregs > (1 << m)) nregs = 1 << m;
    end
    j = c + 1;
    for (int k = 0; k < nregs; k++) begin
      while (stall_pat[j] && j < NCYC - 2) j++;
      t        = j + 1;
      e_rdv[t] = 1'b1;
      e_raA[t] = 5'((a + k) % 32);
      e_raB[t] = 5'((b + k) % 32);
      e_op[t]  = 3'(op);
      mask     = 16'hFFFF;
`ifdef RVV_VSEQ_TAIL_MASK_EN
      rem = l - k * epr;
      if (rem > epr) rem = epr;
      nb = rem * (1 << s);
      if (nb < 16) mask = 16'((1 << nb) - 1);
`endif
      e_wen[t + EX_LAT] = 1'b1;
      e_wa[t + EX_LAT]  = 5'((d + k) % 32);
      e_wbe[t + EX_LAT] = mask;
      j++;
    end
    fin = (nregs == 0) ? c + 2 : t + EX_LAT + 1;
    e_done[fin] = 1'b1;
    e_err[fin]  = ill;
    for (int i = c + 1; i < fin; i++) e_busy[i] = 1'b1;
  endtask

  task automatic compare_cycle();
    check_eq("in_ready", in_ready, !e_busy[cyc]);
    check_eq("busy", busy, e_busy[cyc]);
    check_eq("rd_valid", rd_valid, e_rdv[cyc]);
    if (e_rdv[cyc]) begin
      check_eq("raA", raA, e_raA[cyc]);
      check_eq("raB", raB, e_raB[cyc]);
      check_eq("valu_op", valu_op, e_op[cyc]);
    end
    check_eq("wen", wen, e_wen[cyc]);
    if (e_wen[cyc]) begin
      check_eq("wa", wa, e_wa[cyc]);
      check_eq("wbe", wbe, e_wbe[cyc]);
    end
    check_eq("done", done, e_done[cyc]);
    check_eq("err", err, e_err[cyc]);
  endtask

  task automatic run_cycle();
    stall = stall_pat[cyc];
    if (in_valid && !e_busy[cyc]) begin
      plan(cyc, in_vs1, in_vs2, in_vd, in_op, vl, sew_enc, lmul_enc);
    end
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle();
    while (e_busy[cyc]) run_cycle();
  endtask

  // Holds in_valid through any busy cycles, then drops it after the accept.
  task automatic send(input int a, input int b, input int d, input int op,
                      input int l, input int s, input int m);
    in_valid = 1'b1;
    in_vs1   = 5'(a);
    in_vs2   = 5'(b);
    in_vd    = 5'(d);
    in_op    = 3'(op);
    vl       = 9'(l);
    sew_enc  = 3'(s);
    lmul_enc = 3'(m);
    wait_idle();
    run_cycle();
    in_valid = 1'b0;
    in_vs1   = 5'($urandom);
    in_vs2   = 5'($urandom);
    in_vd    = 5'($urandom);
    in_op    = 3'($urandom);
    vl       = 9'($urandom);
    sew_enc  = 3'($urandom);
    lmul_enc = 3'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int s, m, l;
    clear_from(0);
    #2;
    check_eq("reset_in_ready", in_ready, 1);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_rd_valid", rd_valid, 0);
    check_eq("reset_wen", wen, 0);
    check_eq("reset_wbe", wbe, 0);
    check_eq("reset_raA", raA, 0);
    check_eq("reset_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_cycle();

    // Tail group: three registers, last one half-written under the tail mask.
    send(4, 8, 12, 3, 10, 2, 2);
    // Zero-length, then clamp of an oversized vl to one register.
    send(1, 2, 3, 4, 0, 0, 0);
    send(7, 9, 11, 5, 200, 0, 0);
    wait_idle();
    run_cycle();

    // Wrap modulo 32 with one stall on the second ISSUE cycle.
    stall_pat[cyc + 2] = 1'b1;
    send(30, 2, 20, 1, 8, 3, 2);
    wait_idle();

    // Illegal vtype, then a back-to-back legal instruction.
    send(3, 3, 3, 6, 40, 5, 1);
    send(5, 6, 7, 2, 33, 1, 3);
    wait_idle();
    run_cycle();

    // Reset while issuing drops the instruction without done.
    send(0, 8, 16, 5, 64, 0, 3);
    run_cycle();
    run_cycle();
    rst = 1'b0;
    #1;
    check_eq("midrst_rd_valid", rd_valid, 0);
    check_eq("midrst_wen", wen, 0);
    check_eq("midrst_raA", raA, 0);
    check_eq("midrst_wa", wa, 0);
    check_eq("midrst_wbe", wbe, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_err", err, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    clear_from(cyc);
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b1;
    repeat (4) run_cycle();

    // Randomized instructions with random stalls and idle gaps.
    for (int i = cyc + 1; i < NCYC; i++) stall_pat[i] = ($urandom_range(0, 3) == 0);
    for (int n = 0; n < 80 && cyc < NCYC - 200; n++) begin
      s = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      m = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 40);
      send($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 7), l, s, m);
      repeat ($urandom_range(0, 2)) run_cycle();
    end
    wait_idle();
    repeat (3) run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
